// File: rtl/sensor_capture_seq_pkg.sv
// Shared constants for the sensor capture sequencer: sensor codes, FSM
// state encodings and the minimum ready-hold length.
package sensor_capture_seq_pkg;

  typedef logic [2:0] sens_code_t;

  localparam sens_code_t SENS_NONE = 3'b000;
  localparam sens_code_t SENS_1    = 3'b001;
  localparam sens_code_t SENS_2    = 3'b010;

  // The memory write sequence needs 4 clk states to finish.
  localparam int HOLD_MIN = 4;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_CONV    = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  function automatic sens_code_t sens_code(input logic ch);
    return ch ? SENS_2 : SENS_1;
  endfunction

endpackage

// File: rtl/sensor_ts_counter.sv
// Tick-driven wrapping timestamp counter with one-deep pending tick and a
// saturating overrun counter for ticks that cannot be queued.
module sensor_ts_counter
  import sensor_capture_seq_pkg::*;
#(
  parameter int TS_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sample_tick,
  input  logic                fsm_idle,
  output logic                launch,
  output logic [TS_WIDTH-1:0] launch_ts,
  output logic [7:0]          overrun_cnt
);

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [TS_WIDTH-1:0] pend_ts_q, pend_ts_d;
  logic                pending_q, pending_d;
  logic [7:0]          ovr_q, ovr_d;
  logic                busy_tick;

  always_comb begin
    launch    = fsm_idle && enable && (sample_tick || pending_q);
    launch_ts = pending_q ? pend_ts_q : ts_q;
    // A tick that cannot launch right now; includes a tick arriving while a
    // pending tick is being consumed from IDLE.
    busy_tick = sample_tick && enable && (!fsm_idle || pending_q);

    ts_d      = sample_tick ? ts_q + 1'b1 : ts_q;
    pending_d = pending_q;
    pend_ts_d = pend_ts_q;
    ovr_d     = ovr_q;

    if (!enable) begin
      pending_d = 1'b0;
    end else if (busy_tick) begin
      if (pending_q && !launch) begin
        if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
      end else begin
        pending_d = 1'b1;
        pend_ts_d = ts_q;
      end
    end else if (launch) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q      <= '0;
      pend_ts_q <= '0;
      pending_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      ts_q      <= ts_d;
      pend_ts_q <= pend_ts_d;
      pending_q <= pending_d;
      ovr_q     <= ovr_d;
    end
  end

  assign overrun_cnt = ovr_q;

endmodule

// File: rtl/sensor_capture_seq.sv
// Sensor capture sequencer: converts sensor 1 then sensor 2 per sample tick
// and presents timestamped results. SENSOR_AVG_EN enables 4x averaging.
//
// state   | meaning
// IDLE    | waiting for an enabled tick or a pending tick
// START   | one-cycle adc_start pulse, timeout timer loaded
// CONV    | waiting for adc_valid or timeout
// PRESENT | ADC_data_ready held for the memory write
// GAP     | one idle cycle between results, then next channel or IDLE
module sensor_capture_seq
  import sensor_capture_seq_pkg::*;
#(
  parameter int CONV_TIMEOUT = 64,
  parameter int HOLD_CYCLES  = 6,
  parameter int TS_WIDTH     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                sample_tick,
  input  logic                adc_valid,
  input  logic [7:0]          adc_result,
  input  logic                mem_done,
  output logic                adc_start,
  output logic                adc_ch,
  output logic [7:0]          ADC_data,
  output logic                ADC_data_ready,
  output logic [2:0]          sensor_code,
  output logic [TS_WIDTH-1:0] sensor_time_stamp,
  output logic                busy,
  output logic [7:0]          overrun_cnt,
  output logic                timeout_err
);

  localparam int HOLD_EFF = (HOLD_CYCLES < HOLD_MIN) ? HOLD_MIN : HOLD_CYCLES;
  localparam int TMO_W    = $clog2(CONV_TIMEOUT + 1);
  localparam int HOLD_W   = $clog2(HOLD_EFF + 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(CONV_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_EFF - 1);

  logic [2:0]          state_q, state_d;
  logic                ch_q, ch_d;
  logic [TS_WIDTH-1:0] ts_lat_q, ts_lat_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [7:0]          data_q, data_d;
  sens_code_t          code_q, code_d;
  logic [TS_WIDTH-1:0] stamp_q, stamp_d;
  logic                terr_q, terr_d;
  logic                md_prev_q;
  logic                md_rise;
  logic                launch;
  logic [TS_WIDTH-1:0] launch_ts;
`ifdef SENSOR_AVG_EN
  logic [1:0]          idx_q, idx_d;
  logic [9:0]          acc_q, acc_d;
  logic [9:0]          sum;
`endif

  sensor_ts_counter #(
    .TS_WIDTH(TS_WIDTH)
  ) u_ts (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sample_tick(sample_tick),
    .fsm_idle   (state_q == ST_IDLE),
    .launch     (launch),
    .launch_ts  (launch_ts),
    .overrun_cnt(overrun_cnt)
  );

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    ts_lat_d = ts_lat_q;
    tmo_d    = tmo_q;
    hold_d   = hold_q;
    data_d   = data_q;
    code_d   = code_q;
    stamp_d  = stamp_q;
    terr_d   = terr_q;
    md_rise  = mem_done && !md_prev_q;
`ifdef SENSOR_AVG_EN
    idx_d    = idx_q;
    acc_d    = acc_q;
    sum      = acc_q + {2'b00, adc_result};
`endif

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          ch_d     = 1'b0;
          ts_lat_d = launch_ts;
          state_d  = ST_START;
`ifdef SENSOR_AVG_EN
          idx_d    = '0;
          acc_d    = '0;
`endif
        end
      end
      ST_START: begin
        tmo_d   = TMO_LOAD;
        state_d = ST_CONV;
      end
      ST_CONV: begin
        if (adc_valid) begin
`ifdef SENSOR_AVG_EN
          if (idx_q != 2'd3) begin
            acc_d   = sum;
            idx_d   = idx_q + 2'd1;
            state_d = ST_START;
          end else begin
            data_d  = sum[9:2];
            code_d  = sens_code(ch_q);
            stamp_d = ts_lat_q;
            hold_d  = HOLD_LOAD;
            idx_d   = '0;
            acc_d   = '0;
            state_d = ST_PRESENT;
          end
`else
          data_d  = adc_result;
          code_d  = sens_code(ch_q);
          stamp_d = ts_lat_q;
          hold_d  = HOLD_LOAD;
          state_d = ST_PRESENT;
`endif
        end else if (tmo_q == '0) begin
          terr_d  = 1'b1;
          state_d = ST_GAP;
`ifdef SENSOR_AVG_EN
          idx_d   = '0;
          acc_d   = '0;
`endif
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      ST_PRESENT: begin
        if (hold_q == '0 || md_rise) begin
          state_d = ST_GAP;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (!ch_q) begin
          ch_d    = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= 1'b0;
      ts_lat_q  <= '0;
      tmo_q     <= '0;
      hold_q    <= '0;
      data_q    <= '0;
      code_q    <= SENS_NONE;
      stamp_q   <= '0;
      terr_q    <= 1'b0;
      md_prev_q <= 1'b0;
`ifdef SENSOR_AVG_EN
      idx_q     <= '0;
      acc_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      ts_lat_q  <= ts_lat_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      data_q    <= data_d;
      code_q    <= code_d;
      stamp_q   <= stamp_d;
      terr_q    <= terr_d;
      md_prev_q <= mem_done;
`ifdef SENSOR_AVG_EN
      idx_q     <= idx_d;
      acc_q     <= acc_d;
`endif
    end
  end

  assign adc_start         = (state_q == ST_START);
  assign adc_ch            = ch_q;
  assign ADC_data          = data_q;
  assign ADC_data_ready    = (state_q == ST_PRESENT);
  assign sensor_code       = (state_q == ST_PRESENT) ? code_q : SENS_NONE;
  assign sensor_time_stamp = stamp_q;
  assign busy              = (state_q != ST_IDLE);
  assign timeout_err       = terr_q;

endmodule
